count_ture_bcd: RTL

Parametrised lap counter for the line-follower car. Synchronises the raw lap-marker sensor signal and detects its rising edge. Rejects re-triggers inside a hold-off window and counts accepted laps in a multi-digit BCD register that feeds the 7-segment display decoders directly. Adds clear, enable, wrap/saturate mode, overflow flag and a per-lap strobe.

---
 rtl/count_ture_bcd.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/count_ture_bcd.sv
// ---------------------------------------------------------------------------
// count_ture_bcd
//
// Lap counter for the line-follower car. The raw lap-marker sensor is
// synchronised into the tact domain and its rising edge detected. Accepted
// laps increment a multi-digit BCD register that drives the 7-segment
// decoders directly.
//
// Parameters:
//   DIGITS       number of BCD digits (1..6)
//   HOLDOFF_CYC  cycles after an accepted lap during which edges are ignored
//                (>= 1; only used when COUNT_TURE_BCD_HOLDOFF_EN is defined)
//   SATURATE     0 = wrap to zero past all-nines, 1 = stick at all-nines
//
// Ports:
//   tact        system clock, rising edge
//   reset_n     synchronous active-low reset
//   lap_in      raw lap-marker sensor, asynchronous to tact
//   enable      1 = accept laps, 0 = edges are discarded
//   clear       synchronous count clear, active high
//   bcd         packed BCD count, digit i in [4i+3:4i], units in [3:0]
//   lap_strobe  one-cycle pulse whenever a lap changes the count
//   overflow    sticky flag, set when a lap arrives at all-nines
//
// Configuration macro: COUNT_TURE_BCD_HOLDOFF_EN
//   defined   -> hold-off counter built, re-triggers inside the window rejected
//   undefined -> no hold-off counter, every enabled synchronised edge counts
// ---------------------------------------------------------------------------
module count_ture_bcd #(
    parameter int DIGITS      = 2,
    parameter int HOLDOFF_CYC = 25_000_000,
    parameter bit SATURATE    = 1'b0
) (
    input  logic                  tact,
    input  logic                  reset_n,
    input  logic                  lap_in,
    input  logic                  enable,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  lap_strobe,
    output logic                  overflow
);

    // Parameter guard: a zero-length hold-off has no meaning, and the
    // counter width below would collapse. Nothing is generated here.
    if (HOLDOFF_CYC < 1) begin : g_holdoff_cyc_invalid
    end

    logic                s1_q, s2_q, s3_q;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_inc;
    logic                lap_strobe_q, lap_strobe_d;
    logic                overflow_q, overflow_d;
    logic                carry;
    logic                at_max;
    logic                rise;
    logic                ho_idle;
    logic                accept;

`ifdef COUNT_TURE_BCD_HOLDOFF_EN
    localparam int HO_W = $clog2(HOLDOFF_CYC + 1);
    logic [HO_W-1:0] ho_q, ho_d;

    assign ho_idle = (ho_q == '0);
`else
    assign ho_idle = 1'b1;
`endif

    assign rise   = s2_q & ~s3_q;
    assign accept = rise & enable & ~clear & ho_idle;

    // Ripple the +1 through the digits. If the carry falls out of the top
    // digit every digit was 9, which is exactly the all-nines condition,
    // and bcd_inc is then all zeros.
    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        at_max = carry;
    end

    // Next-state for count, strobe and flag. Clear outranks a lap in the
    // same cycle; a saturating counter at all-nines still flags overflow
    // but neither changes the count nor strobes.
    always_comb begin
        bcd_d        = bcd_q;
        lap_strobe_d = 1'b0;
        overflow_d   = overflow_q;
        if (clear) begin
            bcd_d      = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            if (at_max) begin
                overflow_d = 1'b1;
                if (!SATURATE) begin
                    bcd_d        = bcd_inc;
                    lap_strobe_d = 1'b1;
                end
            end else begin
                bcd_d        = bcd_inc;
                lap_strobe_d = 1'b1;
            end
        end
    end

`ifdef COUNT_TURE_BCD_HOLDOFF_EN
    // The hold-off reloads on every accepted lap, including a saturated
    // one, and otherwise runs down to zero whether or not enable is high.
    always_comb begin
        ho_d = ho_q;
        if (clear) begin
            ho_d = '0;
        end else if (accept) begin
            ho_d = HO_W'(HOLDOFF_CYC);
        end else if (ho_q != '0) begin
            ho_d = ho_q - HO_W'(1);
        end
    end
`endif

    // All state registers. The synchroniser chain is left alone by clear
    // so a level already high is never re-detected as a new edge.
    always_ff @(posedge tact) begin
        if (!reset_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            bcd_q        <= '0;
            lap_strobe_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef COUNT_TURE_BCD_HOLDOFF_EN
            ho_q         <= '0;
`endif
        end else begin
            s1_q         <= lap_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            bcd_q        <= bcd_d;
            lap_strobe_q <= lap_strobe_d;
            overflow_q   <= overflow_d;
`ifdef COUNT_TURE_BCD_HOLDOFF_EN
            ho_q         <= ho_d;
`endif
        end
    end

    assign bcd        = bcd_q;
    assign lap_strobe = lap_strobe_q;
    assign overflow   = overflow_q;

endmodule
